// File: rtl/ps2_keyboard_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_keyboard_decoder                                          |
// | Purpose  : Receives raw PS/2 keyboard frames, validates start, parity,   |
// |            stop and timeout, and decodes set-2 scancodes into one-cycle  |
// |            arrow/backspace pulses or an ASCII symbol code.               |
// | Ports    : clk, rst (async, active-high)   - clock and reset             |
// |            ps2_clk, ps2_data               - raw asynchronous PS/2 lines |
// |            keyboard_left/right/backspace   - one-cycle key pulses        |
// |            keyboard_symbol                 - ASCII for one cycle, else 0 |
// |            frame_error                     - one-cycle bad-frame pulse   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_keyboard_decoder #(
  parameter int SYMBOL_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  output logic                    keyboard_left,
  output logic                    keyboard_right,
  output logic                    keyboard_backspace,
  output logic [SYMBOL_WIDTH-1:0] keyboard_symbol,
  output logic                    frame_error
);

  localparam int              c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_t;

  // Synchronisers and edge history
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_edge;

  // Receiver
  rx_state_t        r_state, w_state_nx;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic             r_par;
  logic [c_TO_W-1:0] r_to_cnt;
  logic             w_byte_ok, w_byte_bad, w_timeout;
  logic             r_byte_valid;
  logic             r_frame_err;

  // Decoder
  logic                    r_ext, r_brk, r_shift_l, r_shift_r;
  logic                    w_shift;
  logic                    r_left, r_right, r_bs;
  logic [SYMBOL_WIDTH-1:0] r_sym;

  // ------------------------------------------------------------------------
  // Two-flop synchronisers; falling edge of the synced PS/2 clock
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_edge = r_clk_prev & ~r_clk_s2;

  // ------------------------------------------------------------------------
  // Receiver FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Receiver FSM: next state and frame verdicts. A timeout only fires when
  // no edge arrives in the same cycle, since an edge restarts the count.
  always_comb begin
    w_state_nx = r_state;
    w_byte_ok  = 1'b0;
    w_byte_bad = 1'b0;
    w_timeout  = 1'b0;
    if ((r_state != S_IDLE) && !w_edge && (r_to_cnt == c_TO_MAX)) begin
      w_timeout  = 1'b1;
      w_state_nx = S_IDLE;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) w_state_nx = S_DATA;
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) w_state_nx = S_PARITY;
        end
        S_PARITY: begin
          w_state_nx = S_STOP;
        end
        S_STOP: begin
          w_state_nx = S_IDLE;
          // Odd parity: data plus parity bit must hold an odd count of ones
          if (r_dat_s2 && (^{r_shreg, r_par})) w_byte_ok  = 1'b1;
          else                                 w_byte_bad = 1'b1;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Receiver datapath, timeout counter and frame verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= 3'd0;
      r_shreg      <= 8'h00;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_ok;
      r_frame_err  <= w_byte_bad | w_timeout;

      if ((r_state == S_IDLE) || w_edge || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + 1'b1;

      if (w_edge) begin
        case (r_state)
          S_IDLE: r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_shreg   <= {r_dat_s2, r_shreg[7:1]};  // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par <= r_dat_s2;
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------------
  // Scancode to ASCII lookup; 0 means the code has no symbol
  // ------------------------------------------------------------------------
  function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = shift ? 8'h29 : 8'h30;
      8'h16: a = shift ? 8'h00 : 8'h31;
      8'h1E: a = shift ? 8'h00 : 8'h32;
      8'h26: a = shift ? 8'h00 : 8'h33;
      8'h25: a = shift ? 8'h00 : 8'h34;
      8'h2E: a = shift ? 8'h00 : 8'h35;
      8'h36: a = shift ? 8'h5E : 8'h36;
      8'h3D: a = shift ? 8'h00 : 8'h37;
      8'h3E: a = shift ? 8'h2A : 8'h38;
      8'h46: a = shift ? 8'h28 : 8'h39;
      8'h55: a = shift ? 8'h2B : 8'h3D;
      8'h4E: a = 8'h2D;
      8'h4A: a = 8'h2F;
      8'h49: a = 8'h2E;
      8'h29: a = 8'h20;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign w_shift = r_shift_l | r_shift_r;

  // ------------------------------------------------------------------------
  // Decoder: prefix tracking, shift state and registered output pulses
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_bs      <= 1'b0;
      r_sym     <= '0;
    end else begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_bs    <= 1'b0;
      r_sym   <= '0;
      if (r_frame_err) begin
        // A lost byte may have been part of a prefixed sequence
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_valid) begin
        if (r_shreg == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shreg == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_ext) begin
            if (!r_brk) begin
              if (r_shreg == 8'h6B)      r_left  <= 1'b1;
              else if (r_shreg == 8'h74) r_right <= 1'b1;
            end
          end else if (r_shreg == 8'h12) begin
            r_shift_l <= !r_brk;
          end else if (r_shreg == 8'h59) begin
            r_shift_r <= !r_brk;
          end else if (!r_brk) begin
            if (r_shreg == 8'h66) r_bs  <= 1'b1;
            else                  r_sym <= SYMBOL_WIDTH'(f_ascii(r_shreg, w_shift));
          end
        end
      end
    end
  end

  assign keyboard_left      = r_left;
  assign keyboard_right     = r_right;
  assign keyboard_backspace = r_bs;
  assign keyboard_symbol    = r_sym;
  assign frame_error        = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_keyboard_decoder                                       |
// | Purpose  : Directed self-checking bench for ps2_keyboard_decoder.        |
// |            Drives PS/2 frames and checks output pulses and timing.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ps2_keyboard_decoder;

  localparam int c_SW   = 7;
  localparam int c_TO   = 200;
  localparam int c_HALF = 20;   // clk cycles per PS/2 half bit

  logic             clk;
  logic             rst;
  logic             ps2_clk;
  logic             ps2_data;
  logic             keyboard_left;
  logic             keyboard_right;
  logic             keyboard_backspace;
  logic [c_SW-1:0]  keyboard_symbol;
  logic             frame_error;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_keyboard_decoder #(
    .SYMBOL_WIDTH   (c_SW),
    .TIMEOUT_CYCLES (c_TO)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .ps2_clk            (ps2_clk),
    .ps2_data           (ps2_data),
    .keyboard_left      (keyboard_left),
    .keyboard_right     (keyboard_right),
    .keyboard_backspace (keyboard_backspace),
    .keyboard_symbol    (keyboard_symbol),
    .frame_error        (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector {left, right, backspace, symbol}
  function automatic logic [c_SW+2:0] f_outs();
    return {keyboard_left, keyboard_right, keyboard_backspace, keyboard_symbol};
  endfunction

  function automatic logic [c_SW+2:0] f_sym(input logic [6:0] s);
    return {3'b000, s};
  endfunction

  localparam logic [c_SW+2:0] c_LEFT  = {3'b100, 7'h00};
  localparam logic [c_SW+2:0] c_RIGHT = {3'b010, 7'h00};
  localparam logic [c_SW+2:0] c_BS    = {3'b001, 7'h00};
  localparam logic [c_SW+2:0] c_NONE  = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One PS/2 bit: data set up, falling edge, rising edge
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (c_HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (c_HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame. After the stop-bit falling edge (driven on a negedge), the
  // synced edge is seen in cycle 2, byte_valid in 3, the output in 4.
  task automatic send(input logic [7:0] b, input logic bad_par,
                      input logic [c_SW+2:0] exp, input int exp_err);
    logic par;
    int   errs;
    par  = (~^b) ^ bad_par;
    errs = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (c_HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 1; k <= c_HALF; k++) begin
      @(negedge clk);
      if (frame_error) errs++;
      if (k == 4)                chk($sformatf("out_%02h", b), 32'(f_outs()), 32'(exp));
      else if (k == 3 || k == 5) chk($sformatf("quiet_%02h", b), 32'(f_outs()), 32'(c_NONE));
    end
    ps2_clk = 1'b1;
    repeat (c_HALF) @(negedge clk);
    chk($sformatf("err_%02h", b), 32'(errs), 32'(exp_err));
  endtask

  // Start bit plus n data bits, then stop driving
  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(i[0]);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int outs;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({f_outs(), frame_error}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Make and break of 'a'
    send(8'h1C, 1'b0, f_sym(7'h61), 0);
    send(8'hF0, 1'b0, c_NONE, 0);
    send(8'h1C, 1'b0, c_NONE, 0);

    // Shifted digits and symbols
    send(8'h12, 1'b0, c_NONE, 0);
    send(8'h3E, 1'b0, f_sym(7'h2A), 0);
    send(8'h16, 1'b0, c_NONE, 0);
    send(8'h55, 1'b0, f_sym(7'h2B), 0);
    send(8'h1C, 1'b0, f_sym(7'h61), 0);
    send(8'hF0, 1'b0, c_NONE, 0);
    send(8'h12, 1'b0, c_NONE, 0);
    send(8'h3E, 1'b0, f_sym(7'h38), 0);
    send(8'h55, 1'b0, f_sym(7'h3D), 0);

    // Extended arrows, extended break, backspace
    send(8'hE0, 1'b0, c_NONE, 0);
    send(8'h6B, 1'b0, c_LEFT, 0);
    send(8'hE0, 1'b0, c_NONE, 0);
    send(8'h74, 1'b0, c_RIGHT, 0);
    send(8'hE0, 1'b0, c_NONE, 0);
    send(8'hF0, 1'b0, c_NONE, 0);
    send(8'h6B, 1'b0, c_NONE, 0);
    send(8'h66, 1'b0, c_BS, 0);

    // Parity error then a good frame
    send(8'h1C, 1'b1, c_NONE, 1);
    send(8'h1C, 1'b0, f_sym(7'h61), 0);

    // Partial frame abandoned by timeout
    send_partial(4);
    errs = 0;
    outs = 0;
    for (int k = 0; k < c_TO + 10; k++) begin
      @(negedge clk);
      if (frame_error) errs++;
      if (f_outs() != c_NONE) outs++;
    end
    chk("timeout_err", 32'(errs), 32'd1);
    chk("timeout_outs", 32'(outs), 32'd0);
    send(8'h45, 1'b0, f_sym(7'h30), 0);

    // Shift held, reset mid-frame, shift must be forgotten
    send(8'h12, 1'b0, c_NONE, 0);
    send_partial(3);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_outs", 32'({f_outs(), frame_error}), 32'd0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h3E, 1'b0, f_sym(7'h38), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
